// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a combinational instr_mem.
// Owns the program counter, queues fetched {pc, instr} pairs in a small
// in-order circular buffer, hands them to decode over valid/ready, accepts
// redirects from execute/branch logic and stops fetching at the halt word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] instrCode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];

  logic             pop;
  logic             push;
  logic             redirect_take;
  logic             queue_full;
  logic             fetch_is_halt;
  logic [31:0]      redirect_target;
  entry_t           head;

  // Handshake and fetch qualifiers shared by the state, PC and queue logic.
  always_comb begin
    redirect_target = redirect_pc & ~32'h0000_0003;
    queue_full      = (count_q == DEPTH_CNT);
    pop             = out_valid && out_ready;
    redirect_take   = redirect_valid && (state_q != ST_BOOT);
    push            = (state_q == ST_RUN) && !redirect_valid && (!queue_full || pop);
    fetch_is_halt   = (instrCode == HALT_INSTR);
  end

  // Next-state logic: BOOT lasts one cycle, a pushed halt word parks the
  // fetcher in HALT, and a taken redirect always lands back in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_take) begin
          state_d = ST_RUN;
        end else if (push && fetch_is_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (redirect_take) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Program counter: redirect wins, otherwise step by one word per push
  // and let the add wrap naturally at the top of the address space.
  always_comb begin
    pc_d = pc_q;
    if (redirect_take) begin
      pc_d = redirect_target;
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Queue bookkeeping: a redirect flushes everything (including any pop
  // decode thought it made this cycle); otherwise push at the tail and pop
  // at the head independently, adjusting the count only when they differ.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (redirect_take) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        entry_d[wr_ptr_q].pc    = pc_q;
        entry_d[wr_ptr_q].instr = instrCode;
        wr_ptr_d                = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous active-low reset; reset also empties
  // the queue so nothing fetched before it can reach decode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Head outputs are forced to zero when the queue is empty so decode never
  // sees a stale entry left behind in the buffer.
  always_comb begin
    head      = entry_q[rd_ptr_q];
    out_valid = (count_q != '0);
    out_pc    = out_valid ? head.pc : 32'd0;
    out_instr = out_valid ? head.instr : 32'd0;
    PC        = pc_q;
    halted    = (state_q == ST_HALT);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with directed scenarios and random
// traffic, and compares every cycle against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] HALT_INSTR = 32'h0000_0073;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] instrCode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  logic        halt_en   = 1'b0;
  logic [31:0] halt_addr = 32'h0;

  int vectors = 0;
  int errors  = 0;

  entry_t      model_q[$];
  logic [31:0] model_pc;
  bit          model_boot;
  bit          model_halt;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .DEPTH     (DEPTH),
    .HALT_INSTR(HALT_INSTR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC            (PC),
    .instrCode     (instrCode),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: fixed words at 0 and 4, an address-derived
  // pattern elsewhere, and an optional ecall placed at halt_addr.
  function automatic logic [31:0] memWord(input logic [31:0] addr, input logic hen,
                                          input logic [31:0] haddr);
    logic [31:0] w;
    w = {addr[29:0], 2'b11} ^ 32'h0100_0000;
    if (addr == 32'h0) w = 32'h0000_0013;
    if (addr == 32'h4) w = 32'h00a0_0093;
    if (w == HALT_INSTR) w = 32'h0000_0013;
    if (hen && addr == haddr) w = HALT_INSTR;
    return w;
  endfunction

  assign instrCode = memWord(PC, halt_en, halt_addr);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compares every visible output against the model after an edge.
  task automatic checkAll();
    logic [31:0] exp_pc, exp_instr;
    exp_pc    = (model_q.size() != 0) ? model_q[0].pc : 32'h0;
    exp_instr = (model_q.size() != 0) ? model_q[0].instr : 32'h0;
    checkOutput("out_valid", {31'h0, out_valid}, {31'h0, model_q.size() != 0});
    checkOutput("out_pc", out_pc, exp_pc);
    checkOutput("out_instr", out_instr, exp_instr);
    checkOutput("PC", PC, model_pc);
    checkOutput("halted", {31'h0, halted}, {31'h0, model_halt});
  endtask

  // Applies one cycle of inputs, advances the model by the behaviour
  // expected at the coming edge, steps the clock and checks the result.
  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    entry_t e;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    if (!r) begin
      model_q.delete();
      model_pc   = RESET_PC;
      model_boot = 1'b1;
      model_halt = 1'b0;
    end else if (model_boot) begin
      model_boot = 1'b0;
    end else if (rv) begin
      model_q.delete();
      model_pc   = {rpc[31:2], 2'b00};
      model_halt = 1'b0;
    end else begin
      if (model_q.size() != 0 && rdy) void'(model_q.pop_front());
      if (!model_halt && model_q.size() < DEPTH) begin
        e.pc    = model_pc;
        e.instr = memWord(model_pc, halt_en, halt_addr);
        model_q.push_back(e);
        if (e.instr == HALT_INSTR) model_halt = 1'b1;
        model_pc = model_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    model_pc = RESET_PC; model_boot = 1'b1; model_halt = 1'b0;

    // Reset release and streaming.
    doReset();
    checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("boot_valid", {31'h0, out_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("first_pc", out_pc, 32'h0);
    checkOutput("first_instr", out_instr, 32'h0000_0013);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Backpressure after the first push.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("bp_pc_hold", PC, 32'h8);
    checkOutput("bp_head", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect with a full queue, aligned then unaligned target.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1);
    checkOutput("redir_flush", {31'h0, out_valid}, 32'h0);
    checkOutput("redir_pc", PC, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("redir_head", out_pc, 32'h40);
    applyStimulus(1'b1, 1'b1, 32'h43, 1'b1);
    checkOutput("redir_unaligned", PC, 32'h40);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Halt at 0xC, stay halted, then restart by redirect.
    halt_en = 1'b1; halt_addr = 32'hC;
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("halt_flag", {31'h0, halted}, 32'h1);
    checkOutput("halt_pc", PC, 32'h10);
    halt_en = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b1);
    checkOutput("unhalt", {31'h0, halted}, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Address wrap at the top of memory.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_head", out_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_next", out_pc, 32'h0);

    // Reset mid-stream with the queue full.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("midrst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("midrst_pc", PC, RESET_PC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("midrst_boot", {31'h0, out_valid}, 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r, rv, rdy;
      logic [31:0] rpc;
      if ($urandom_range(0, 99) < 10) begin
        halt_en   = $urandom_range(0, 1) == 1;
        halt_addr = 32'($urandom_range(0, 40)) << 2;
      end
      r   = $urandom_range(0, 99) >= 2;
      rv  = $urandom_range(0, 99) < 6;
      rpc = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 200));
      rdy = $urandom_range(0, 99) < 70;
      applyStimulus(r, rv, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of `instr_mem`. It owns the program counter, drives `PC` into the combinational instruction memory, and captures the returned `instrCode` into a small in-order fetch queue. Decode consumes the queue through a valid/ready handshake. A redirect port lets execute or branch logic steer fetch, and fetch stops at `ecall`.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset. Must be word-aligned.
- `DEPTH`, default `2`: fetch queue entries. Must be a power of 2, at least 2.
- `HALT_INSTR`, default `32'h0000_0073` (`ecall`): instruction word that stops fetching.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `PC`  out  32  fetch address to `instr_mem`.
- `instrCode`  in  32  combinational instruction word returned for `PC`.
- `redirect_valid`  in  1  request a fetch redirect this cycle.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- `out_valid`  out  1  queue head holds an instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  instruction at the queue head.
- `out_pc`  out  32  address of `out_instr`.
- `halted`  out  1  fetch has stopped on `HALT_INSTR`.

## Operation
FSM states and transitions:
- **BOOT**
  - Entered on reset.
  - Held for exactly one cycle after `rst` rises so `instr_mem` contents are stable.
  - No fetch; next state is RUN.
- **RUN**
  - Fetches one instruction per cycle when the push condition (below) holds.
- **HALT**
  - No fetch; the queue still drains.
  - Left only by reset or a redirect.

Queue:
- Circular buffer of `DEPTH` entries, each holding {pc, instr}, with read/write pointers and a count of width clog2(`DEPTH`)+1.
- Pop when `out_valid` and `out_ready` are both high.
- Push when state is RUN, no redirect, and (count < `DEPTH` or pop this cycle).
- A push writes {`PC`, `instrCode`} and sets PC <= PC + 4. The add is modulo 2^32: `32'hFFFF_FFFC` wraps to 0.
- Simultaneous push and pop leaves count unchanged.

Halt:
- If a pushed `instrCode` equals `HALT_INSTR`, the halt word itself is still queued.
- PC still advances to halt address + 4; state goes to HALT.
- `halted` = 1 while in HALT.

Redirect (highest priority, any state except BOOT):
- At the clock edge the queue is flushed: count = 0, pointers = 0.
- Any pop in that cycle is discarded: decode must treat a redirect as a kill.
- PC <= {`redirect_pc`[31:2], 2'b00}; state <= RUN.
- No push in the redirect cycle.
- A redirect during BOOT is ignored.

Outputs:
- `out_valid` = (count != 0); `out_instr` and `out_pc` show the head entry.
- Head outputs are undefined-but-stable when `out_valid` = 0. Implement them as 0.

## Timing
Reset (`rst` = 0 at an edge):
- State = BOOT, PC = `RESET_PC`, count = 0, pointers = 0.
- `out_valid` = 0, `out_instr` = 0, `out_pc` = 0, `halted` = 0.
- Reset mid-operation discards all queued entries in the same edge.

Latency:
- First push occurs at the second rising edge after `rst` rises (the BOOT edge, then the RUN edge).
- `out_valid` rises after that second edge.
- Fetch-to-head latency is 1 cycle when the queue is empty.
- After a redirect edge, the target instruction is at the head 1 cycle later.

Throughput and backpressure:
- Sustained rate is 1 instruction per cycle with `out_ready` held high.
- When full (count = `DEPTH`) with `out_ready` = 0: PC holds, no push, head stable.
- Head is held stable while `out_valid` = 1 and `out_ready` = 0, unless reset or redirect.

## Test plan
- Reset release, `RESET_PC`=0, memory words 0x00000013, 0x00a00093, ..., `out_ready`=1:
  - `out_valid` rises on the 2nd edge with `out_pc`=0, `out_instr`=0x00000013.
  - Then `out_pc` = 4, 8, 12 on consecutive cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles after the first push:
  - count saturates at 2, PC holds at 8, head stays `out_pc`=0.
  - Releasing `out_ready` drains `out_pc` 0, 4, 8 with no gaps or duplicates.
- Redirect with a full queue, `redirect_pc`=0x40, same cycle as `out_ready`=1:
  - Next cycle `out_valid`=0, PC=0x40.
  - Following cycle head `out_pc`=0x40.
  - Repeat with `redirect_pc`=0x43: fetch goes to 0x40.
- Halt: `ecall` at 0x0C:
  - Entries 0x0, 0x4, 0x8, 0xC are delivered, then `halted`=1, PC=0x10.
  - No further pushes for 10 cycles.
  - A redirect to 0x0 clears `halted` and fetch resumes at 0x0.
- Wrap: redirect to 0xFFFFFFFC:
  - Entries 0xFFFFFFFC, then 0x00000000 are delivered.
- Reset asserted mid-stream with 2 entries queued:
  - After the edge `out_valid`=0, PC=`RESET_PC`, `halted`=0.
  - One BOOT cycle occurs before fetching resumes.
